// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared definitions for the round-robin arbiter controller.
//   - FSM state encoding (ST_IDLE / ST_GRANT)
//   - vec_t: fixed-width carrier so helpers work for any N < MAX_N
//   - onehot2idx(): one-hot vector -> binary index
//   - rotate_right(): rotate the low n bits of a vector right by one
//   - is_onehot(): exactly one bit set
package rr_arb_pkg;

  typedef logic state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_GRANT = 1'b1;

  localparam int MAX_N = 64;
  localparam int IDXW  = $clog2(MAX_N);
  typedef logic [MAX_N-1:0] vec_t;

  // OR of the indices of all set bits; exact for a one-hot input.
  function automatic logic [IDXW-1:0] onehot2idx(input vec_t v);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++)
      if (v[i]) r = r | IDXW'(i);
    return r;
  endfunction

  // Rotate the low n bits right by one: bit 0 wraps to bit n-1.
  function automatic vec_t rotate_right(input vec_t v, input int n);
    vec_t r;
    r = v >> 1;
    r[n-1] = v[0];
    return r;
  endfunction

  function automatic logic is_onehot(input vec_t v);
    return (v != '0) && ((v & (v - vec_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational round-robin winner search.
//   ptr     in  N   one-hot priority pointer (highest-priority requester)
//   req     in  N   request vector
//   win_oh  out N   one-hot winner (0 if no request)
//   win_idx out IW  binary winner index (0 if no request)
//   win_vld out 1   any request present
// Search order is ptr, ptr-1, ..., 0, N-1, ... . Requests are duplicated into
// a 2N-bit vector; the window (p, p+N] of that vector lists every requester
// exactly once, and its highest set bit is the first hit of the downward walk.
module rr_priority_pick
  import rr_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  ptr,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx,
  output logic          win_vld
);

  always_comb begin
    vec_t           ext;
    logic [2*N-1:0] dbl;
    int             p;
    int             hi;
    ext          = '0;
    ext[N-1:0]   = ptr;
    p            = int'(onehot2idx(ext));
    dbl          = {req, req};
    hi           = 0;
    win_vld      = 1'b0;
    for (int j = 0; j < 2*N; j++)
      if (dbl[j] && (j > p) && (j <= p + N)) begin
        hi      = j;
        win_vld = 1'b1;
      end
    win_idx = IW'((hi >= N) ? hi - N : hi);
    for (int i = 0; i < N; i++)
      win_oh[i] = win_vld && (int'(win_idx) == i);
  end

endmodule

// File: rtl/rr_arbiter_ctrl.sv
// rr_arbiter_ctrl: round-robin arbiter sharing one resource among N requesters.
//   clk        in   1   rising-edge clock
//   reset_n    in   1   asynchronous active-low reset
//   req        in   N   level request per requester
//   done       in   1   owner release pulse (only looked at in GRANT)
//   grant      out  N   registered one-hot grant, 0 when idle
//   grant_idx  out  IW  binary index of grant, 0 when idle
//   busy       out  1   high while a grant is held
//   timeout    out  1   one-cycle pulse on forced release
// Optional feature: define RR_ARB_TIMEOUT_EN to force release after MAX_HOLD
// grant cycles; otherwise timeout is tied low and an owner may hold forever.
// Arbitration only happens in IDLE, so each handover has one idle bubble.
module rr_arbiter_ctrl
  import rr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 busy,
  output logic                 timeout
);

  localparam int         IW      = $clog2(N);
  localparam logic [N-1:0] PTR_RST = {1'b1, {(N-1){1'b0}}};

  if (N < 2 || N >= MAX_N || MAX_HOLD < 2) begin : g_param_chk
    $error("rr_arbiter_ctrl: need 2 <= N < MAX_N and MAX_HOLD >= 2");
  end

  state_t        state_q, state_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          to_q, to_d;

  logic [N-1:0]  win_oh;
  logic [IW-1:0] win_idx;
  logic          win_vld;
  logic          norm_rel, force_rel, rel;

  rr_priority_pick #(.N(N), .IW(IW)) u_pick (
    .ptr     (ptr_q),
    .req     (req),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_vld (win_vld)
  );

  assign norm_rel = done || !req[idx_q];
  assign rel      = norm_rel || force_rel;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD) + 1;
  logic [CW-1:0] hold_q;

  // Held at 0 in IDLE so it reads 0 in the first GRANT cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                hold_q <= '0;
    else if (state_q == ST_IDLE) hold_q <= '0;
    else                         hold_q <= hold_q + CW'(1);
  end

  assign force_rel = (state_q == ST_GRANT) && (hold_q == CW'(MAX_HOLD - 1));
`else
  assign force_rel = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_RST;
      grant_q <= '0;
      idx_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      to_q    <= to_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (win_vld) state_d = ST_GRANT;
      ST_GRANT: if (rel)     state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next registered outputs and pointer.
  vec_t rot_w;
  logic unused_rot;
  assign unused_rot = ^rot_w[MAX_N-1:N];

  always_comb begin
    vec_t ext;
    ext        = '0;
    ext[N-1:0] = win_oh;
    rot_w      = rotate_right(ext, N);

    grant_d = grant_q;
    idx_d   = idx_q;
    to_d    = 1'b0;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: if (win_vld) begin
        grant_d = win_oh;
        idx_d   = win_idx;
      end
      ST_GRANT: if (rel) begin
        grant_d = '0;
        idx_d   = '0;
        to_d    = force_rel && !norm_rel;
      end
      default: ;
    endcase
    // Winner becomes lowest priority; a corrupted pointer is reloaded.
    if (state_q == ST_IDLE && win_vld) ptr_d = rot_w[N-1:0];
    else if (!is_onehot(vec_t'(ptr_q))) ptr_d = PTR_RST;
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = (state_q == ST_GRANT);
  assign timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter_ctrl.sv
// Bench for rr_arbiter_ctrl (N=4, MAX_HOLD=4): directed vector table,
// hand-written reset/timeout sequences, and randomized traffic against a
// behavioural model tracking owner / priority index / held cycle count.
module tb_rr_arbiter_ctrl;

  localparam int N    = 4;
  localparam int MAXH = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic [1:0]   grant_idx;
  logic         busy;
  logic         timeout;

  rr_arbiter_ctrl #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model state.
  int owner;   // -1 when idle
  int prio;    // highest-priority requester index
  int held;    // grant cycles so far
  bit mto;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       busy;
  } tv_t;
  tv_t tbl[$];

  function automatic logic [7:0] outs();
    return {timeout, busy, grant_idx, grant};
  endfunction

  function automatic logic [7:0] model_outs();
    logic [3:0] g;
    logic [1:0] ix;
    g  = (owner >= 0) ? 4'(1 << owner) : 4'b0;
    ix = (owner >= 0) ? 2'(owner) : 2'd0;
    return {mto, owner >= 0, ix, g};
  endfunction

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %b want %b", nm, act, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    owner = -1; prio = N - 1; held = 0; mto = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    mto = 1'b0;
    if (owner < 0) begin
      for (int k = 0; k < N; k++)
        if (owner < 0 && r[(prio - k + N) % N]) owner = (prio - k + N) % N;
      if (owner >= 0) begin
        prio = (owner + N - 1) % N;
        held = 1;
      end
    end else if (d || !r[owner]) begin
      owner = -1;
    end else if (TO_EN && held == MAXH) begin
      owner = -1;
      mto   = 1'b1;
    end else begin
      held++;
    end
  endtask

  // Apply inputs, advance the model, step one clock, sample 1 ns later.
  task automatic drive(input logic rn, input logic [3:0] r, input logic d);
    reset_n = rn; req = r; done = d;
    if (!rn) model_reset();
    else     model_step(r, d);
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rn, input logic [3:0] r, input logic d,
                     input logic [3:0] g, input logic [1:0] ix, input logic b);
    tv_t t;
    t.rst_n = rn; t.req = r; t.done = d; t.grant = g; t.idx = ix; t.busy = b;
    tbl.push_back(t);
  endtask

  initial begin
    reset_n = 1'b0; req = '0; done = 1'b0;
    model_reset();
    // Two-requester alternation from reset.
    add(1, 4'b0011, 0, 4'b0010, 1, 1);
    add(1, 4'b0011, 1, 4'b0000, 0, 0);
    add(1, 4'b0011, 0, 4'b0001, 0, 1);
    add(1, 4'b0011, 1, 4'b0000, 0, 0);
    add(1, 4'b0011, 0, 4'b0010, 1, 1);
    add(1, 4'b0011, 1, 4'b0000, 0, 0);
    // Owner drops req; done in IDLE ignored; done+drop together.
    add(1, 4'b0100, 0, 4'b0100, 2, 1);
    add(1, 4'b0000, 0, 4'b0000, 0, 0);
    add(1, 4'b0000, 1, 4'b0000, 0, 0);
    add(1, 4'b0010, 1, 4'b0010, 1, 1);
    add(1, 4'b0000, 1, 4'b0000, 0, 0);
    add(1, 4'b0000, 0, 4'b0000, 0, 0);
    // Reset, then all four requesting in strict descending order.
    add(0, 4'b1111, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b1000, 3, 1);
    add(1, 4'b1111, 1, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b0100, 2, 1);
    add(1, 4'b1111, 1, 4'b0000, 0, 0);
    add(1, 4'b1111, 1, 4'b0010, 1, 1);
    add(1, 4'b1111, 1, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b0001, 0, 1);
    add(1, 4'b1111, 1, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 4'b1000, 3, 1);
    add(1, 4'b1111, 1, 4'b0000, 0, 0);

    // Reset state.
    @(posedge clk); #1;
    check("reset_state", outs(), 8'h00);
    reset_n = 1'b1;

    foreach (tbl[i])
      begin
        drive(tbl[i].rst_n, tbl[i].req, tbl[i].done);
        check($sformatf("vec%0d", i), outs(),
              {1'b0, tbl[i].busy, tbl[i].idx, tbl[i].grant});
      end

    // Async reset in the middle of a grant clears outputs without an edge.
    drive(1, 4'b1111, 0);
    check("pre_async_rst", outs(), 8'b0110_0100);
    #3 reset_n = 1'b0;
    #1 check("async_rst_clear", outs(), 8'h00);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    drive(1, 4'b1111, 0);
    check("post_rst_msb", outs(), 8'b0111_1000);
    drive(1, 4'b1111, 1);
    check("post_rst_rel", outs(), 8'h00);

    // Single requester held with no done.
    reset_n = 1'b0; model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    if (TO_EN) begin
      for (int c = 0; c < 4; c++) begin
        drive(1, 4'b0100, 0);
        check($sformatf("hold%0d", c), outs(), 8'b0110_0100);
      end
      drive(1, 4'b0100, 0);
      check("timeout_pulse", outs(), 8'b1000_0000);
      drive(1, 4'b0100, 0);
      check("regrant", outs(), 8'b0110_0100);
      drive(1, 4'b0100, 0);
      check("regrant_hold", outs(), 8'b0110_0100);
    end else begin
      int bad;
      bad = 0;
      for (int c = 0; c < 100; c++) begin
        drive(1, 4'b0100, 0);
        if (outs() !== 8'b0110_0100) bad++;
      end
      check("hold100_bad_cycles", 8'(bad), 8'd0);
      check("hold100_last", outs(), 8'b0110_0100);
    end
    drive(1, 4'b0000, 0);
    check("hold_drop", outs(), 8'h00);

    // Randomized traffic against the model, plus invariants each cycle.
    for (int c = 0; c < 600; c++) begin
      logic       rn;
      logic [3:0] r;
      logic       d;
      rn = ($urandom_range(0, 99) != 0);
      r  = ($urandom_range(0, 3) == 0) ? 4'b1111 : 4'($urandom);
      d  = ($urandom_range(0, 3) == 0);
      drive(rn, r, d);
      check($sformatf("rand%0d", c), outs(), model_outs());
      if (!$onehot0(grant) || busy != (|grant) ||
          (busy && grant != 4'(1 << grant_idx)) || (!busy && grant_idx != 0))
        begin
          n_chk++;
          $display("FAIL invariant%0d: grant=%b idx=%0d busy=%b", c, grant, grant_idx, busy);
        end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
